mc_freq_serial_out: RTL and testbench

MC_FREQ_SERIAL_OUT -- requirements
Module: mc_freq_serial_out

---
 rtl/mc_serial_pkg.sv | 24 ++
 rtl/freq_ch_engine.sv | 141 ++++++++++++++
 rtl/mc_freq_serial_out.sv | 111 +++++++++++
 tb/tb_mc_freq_serial_out.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_serial_pkg.sv
// Shared command-byte layout, channel state encoding and mode constants
// for the multi-channel frequency-pattern serial output block.
package mc_serial_pkg;

  localparam int CMD_START  = 0;
  localparam int CMD_STOP   = 1;
  localparam int CMD_MODE   = 2;
  localparam int CMD_CH_LSB = 3;
  localparam int CMD_CH_MSB = 6;
  localparam int CMD_IDLE   = 7;

  localparam logic MODE_ONESHOT = 1'b0;
  localparam logic MODE_REPEAT  = 1'b1;

  typedef enum logic {
    CH_IDLE = 1'b0,
    CH_RUN  = 1'b1
  } ch_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/freq_ch_engine.sv
// One output channel: shifts a stored pattern out LSB first, each bit held
// TICK_HI or TICK_LO clocks depending on the matching frequency-pattern bit.
module freq_ch_engine
  import mc_serial_pkg::*;
#(
  parameter int DATA_BIT = 8,
  parameter int TICK_LO  = 1000,
  parameter int TICK_HI  = 500
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  input  logic                cmd_start,
  input  logic                cmd_stop,
  input  logic                cmd_mode,
  input  logic                cmd_idle,
  input  logic [DATA_BIT-1:0] out_pat,
  input  logic [DATA_BIT-1:0] freq_pat,
  output logic                serial_out,
  output logic                bit_tick,
  output logic                done_tick,
  output logic                busy
);

  localparam int CW_RAW = $clog2(max_int(TICK_LO, TICK_HI));
  localparam int CW     = (CW_RAW < 1) ? 1 : CW_RAW;
  localparam int IW     = $clog2(DATA_BIT);

  localparam logic [CW-1:0] LEN_LO   = CW'(TICK_LO - 1);
  localparam logic [CW-1:0] LEN_HI   = CW'(TICK_HI - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [IW-1:0] LAST_BIT = IW'(DATA_BIT - 1);

  ch_state_t           state_reg;
  logic [DATA_BIT-1:0] out_pat_reg;
  logic [DATA_BIT-1:0] freq_pat_reg;
  logic [DATA_BIT-1:0] out_sh_reg;
  logic [DATA_BIT-1:0] freq_sh_reg;
  logic [IW-1:0]       bit_idx_reg;
  logic [CW-1:0]       tick_cnt_reg;
  logic                mode_reg;
  logic                idle_reg;
  logic                stop_pend_reg;
  logic                serial_reg;
  logic                bit_tick_reg;
  logic                done_reg;

  logic          restart;
  logic          stop_now;
  logic          bit_last;
  logic          pat_last;
  logic [IW-1:0] idx_next;
  logic [CW-1:0] len_new;
  logic [CW-1:0] len_rep;
  logic [CW-1:0] len_adv;

  assign restart  = cmd_valid & cmd_start;
  assign stop_now = stop_pend_reg | (cmd_valid & cmd_stop);
  assign bit_last = (tick_cnt_reg == '0);
  assign pat_last = (bit_idx_reg == LAST_BIT);
  assign idx_next = bit_idx_reg + IW'(1);
  // Tick counters hold "clocks left in this bit minus one"; zero marks the last clock.
  assign len_new  = freq_pat[0]     ? LEN_HI : LEN_LO;
  assign len_rep  = freq_pat_reg[0] ? LEN_HI : LEN_LO;
  assign len_adv  = freq_sh_reg[1]  ? LEN_HI : LEN_LO;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= CH_IDLE;
      out_pat_reg   <= '0;
      freq_pat_reg  <= '0;
      out_sh_reg    <= '0;
      freq_sh_reg   <= '0;
      bit_idx_reg   <= '0;
      tick_cnt_reg  <= '0;
      mode_reg      <= MODE_ONESHOT;
      idle_reg      <= 1'b0;
      stop_pend_reg <= 1'b0;
      serial_reg    <= 1'b0;
      bit_tick_reg  <= 1'b0;
      done_reg      <= 1'b0;
    end else if (restart) begin
      state_reg     <= CH_RUN;
      out_pat_reg   <= out_pat;
      freq_pat_reg  <= freq_pat;
      out_sh_reg    <= out_pat;
      freq_sh_reg   <= freq_pat;
      bit_idx_reg   <= '0;
      tick_cnt_reg  <= len_new;
      mode_reg      <= cmd_mode;
      idle_reg      <= cmd_idle;
      stop_pend_reg <= 1'b0;
      serial_reg    <= out_pat[0];
      bit_tick_reg  <= (len_new == '0);
      done_reg      <= 1'b0;
    end else if (state_reg == CH_IDLE) begin
      bit_tick_reg <= 1'b0;
      done_reg     <= 1'b0;
      if (cmd_valid && !cmd_stop) begin
        idle_reg   <= cmd_idle;
        serial_reg <= cmd_idle;
      end
    end else if (bit_last) begin
      if (stop_now || (pat_last && mode_reg == MODE_ONESHOT)) begin
        state_reg     <= CH_IDLE;
        serial_reg    <= idle_reg;
        bit_tick_reg  <= 1'b0;
        done_reg      <= 1'b0;
        stop_pend_reg <= 1'b0;
      end else if (pat_last) begin
        out_sh_reg   <= out_pat_reg;
        freq_sh_reg  <= freq_pat_reg;
        bit_idx_reg  <= '0;
        tick_cnt_reg <= len_rep;
        serial_reg   <= out_pat_reg[0];
        bit_tick_reg <= (len_rep == '0);
        done_reg     <= 1'b0;
      end else begin
        out_sh_reg   <= out_sh_reg >> 1;
        freq_sh_reg  <= freq_sh_reg >> 1;
        bit_idx_reg  <= idx_next;
        tick_cnt_reg <= len_adv;
        serial_reg   <= out_sh_reg[1];
        bit_tick_reg <= (len_adv == '0);
        done_reg     <= (len_adv == '0) && (idx_next == LAST_BIT);
      end
    end else begin
      // A stop seen before the last clock of the final bit suppresses its done pulse.
      tick_cnt_reg  <= tick_cnt_reg - CNT_ONE;
      stop_pend_reg <= stop_now;
      bit_tick_reg  <= (tick_cnt_reg == CNT_ONE);
      done_reg      <= (tick_cnt_reg == CNT_ONE) && pat_last && !stop_now;
    end
  end

  assign serial_out = serial_reg;
  assign bit_tick   = bit_tick_reg;
  assign done_tick  = done_reg;
  assign busy       = (state_reg == CH_RUN);

endmodule

// File: rtl/mc_freq_serial_out.sv
// Packet assembler and command decoder feeding NUM_CH independent
// frequency-pattern serial channel engines.
module mc_freq_serial_out
  import mc_serial_pkg::*;
#(
  parameter int DATA_BIT = 8,
  parameter int NUM_CH   = 4,
  parameter int TICK_LO  = 1000,
  parameter int TICK_HI  = 500,
  parameter int TIMEOUT  = 20000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        i_data,
  input  logic              i_rx_done_tick,
  output logic [NUM_CH-1:0] o_serial_out,
  output logic [NUM_CH-1:0] o_bit_tick,
  output logic [NUM_CH-1:0] o_done_tick,
  output logic [NUM_CH-1:0] o_busy,
  output logic              o_cmd_err
);

  localparam int PAT_BYTES = DATA_BIT / 8;
  localparam int PACK_NUM  = 2 * PAT_BYTES + 1;
  localparam int BW        = $clog2(PACK_NUM);
  localparam int TW        = $clog2(TIMEOUT + 1);

  localparam logic [BW-1:0] CMD_POS   = BW'(PACK_NUM - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);
  localparam logic [4:0]    CH_LIMIT  = 5'(NUM_CH);

  logic [7:0]    pkt_mem [0:PACK_NUM-2];
  logic [BW-1:0] byte_cnt_reg;
  logic [TW-1:0] timer_reg;
  logic          cmd_err_reg;

  logic [DATA_BIT-1:0] out_pat;
  logic [DATA_BIT-1:0] freq_pat;
  logic                cmd_valid;
  logic [3:0]          cmd_ch;
  logic                ch_ok;

  // The command byte is decoded straight off i_data so bit 0 appears the next clock.
  assign cmd_valid = i_rx_done_tick && (byte_cnt_reg == CMD_POS);
  assign cmd_ch    = i_data[CMD_CH_MSB:CMD_CH_LSB];
  assign ch_ok     = ({1'b0, cmd_ch} < CH_LIMIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_cnt_reg <= '0;
      timer_reg    <= '0;
      cmd_err_reg  <= 1'b0;
    end else begin
      cmd_err_reg <= cmd_valid && !ch_ok;
      if (i_rx_done_tick) begin
        timer_reg    <= '0;
        byte_cnt_reg <= (byte_cnt_reg == CMD_POS) ? '0 : byte_cnt_reg + BW'(1);
      end else if (byte_cnt_reg != '0) begin
        if (timer_reg == TMO_LAST) begin
          byte_cnt_reg <= '0;
          timer_reg    <= '0;
        end else begin
          timer_reg <= timer_reg + TW'(1);
        end
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < PACK_NUM - 1; gi++) begin : g_pkt
      always_ff @(posedge clk) begin
        if (i_rx_done_tick && byte_cnt_reg == BW'(gi))
          pkt_mem[gi] <= i_data;
      end
    end

    for (gi = 0; gi < PAT_BYTES; gi++) begin : g_pat
      assign out_pat[gi*8 +: 8]  = pkt_mem[gi];
      assign freq_pat[gi*8 +: 8] = pkt_mem[PAT_BYTES + gi];
    end

    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic ch_sel;
      assign ch_sel = cmd_valid && (cmd_ch == 4'(gi));

      freq_ch_engine #(
        .DATA_BIT (DATA_BIT),
        .TICK_LO  (TICK_LO),
        .TICK_HI  (TICK_HI)
      ) u_engine (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (ch_sel),
        .cmd_start  (i_data[CMD_START]),
        .cmd_stop   (i_data[CMD_STOP]),
        .cmd_mode   (i_data[CMD_MODE]),
        .cmd_idle   (i_data[CMD_IDLE]),
        .out_pat    (out_pat),
        .freq_pat   (freq_pat),
        .serial_out (o_serial_out[gi]),
        .bit_tick   (o_bit_tick[gi]),
        .done_tick  (o_done_tick[gi]),
        .busy       (o_busy[gi])
      );
    end
  endgenerate

  assign o_cmd_err = cmd_err_reg;

endmodule

// File: tb/tb_mc_freq_serial_out.sv
// Self-checking bench: directed and random packets compared every clock
// against a time-based model of each channel's waveform.
module tb_mc_freq_serial_out;

  localparam int DB  = 8;
  localparam int NCH = 4;
  localparam int TLO = 4;
  localparam int THI = 2;
  localparam int TMO = 50;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [7:0]     i_data = 8'h00;
  logic           i_rx_done_tick = 1'b0;
  logic [NCH-1:0] o_serial_out;
  logic [NCH-1:0] o_bit_tick;
  logic [NCH-1:0] o_done_tick;
  logic [NCH-1:0] o_busy;
  logic           o_cmd_err;

  always #5 clk = ~clk;

  mc_freq_serial_out #(
    .DATA_BIT (DB),
    .NUM_CH   (NCH),
    .TICK_LO  (TLO),
    .TICK_HI  (THI),
    .TIMEOUT  (TMO)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .i_data         (i_data),
    .i_rx_done_tick (i_rx_done_tick),
    .o_serial_out   (o_serial_out),
    .o_bit_tick     (o_bit_tick),
    .o_done_tick    (o_done_tick),
    .o_busy         (o_busy),
    .o_cmd_err      (o_cmd_err)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Model: each channel is described by when it started and what it was given.
  bit         m_active   [NCH];
  int         m_t0       [NCH];
  logic [7:0] m_out      [NCH];
  logic [7:0] m_freq     [NCH];
  bit         m_rep      [NCH];
  logic       m_idle     [NCH];
  int         m_stop_end [NCH];
  int         m_stop_cmd [NCH];
  logic [7:0] pk [$];
  int         last_t = -1000;
  int         err_t  = -1;

  task automatic chk(input string tag, input int ch, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s ch%0d cycle %0d: got %b expected %b", tag, ch, cyc, obs, exp);
    end
  endtask

  function automatic int bit_len(input logic f);
    return f ? THI : TLO;
  endfunction

  function automatic int period(input logic [7:0] f);
    int s = 0;
    for (int n = 0; n < DB; n++) s += bit_len(f[n]);
    return s;
  endfunction

  task automatic ch_eval(input int c, input int t, output logic s, output logic bt,
                         output logic dn, output logic bs, output int bend);
    int e, per, acc, len;
    s = m_idle[c]; bt = 1'b0; dn = 1'b0; bs = 1'b0; bend = t;
    if (!m_active[c]) return;
    if (m_stop_end[c] >= 0 && t >= m_stop_end[c]) return;
    per = period(m_freq[c]);
    e   = t - m_t0[c];
    if (!m_rep[c] && e >= per) return;
    if (m_rep[c]) e = e % per;
    acc = 0;
    for (int n = 0; n < DB; n++) begin
      len = bit_len(m_freq[c][n]);
      if (e >= acc && e < acc + len) begin
        s    = m_out[c][n];
        bt   = (e == acc + len - 1);
        dn   = bt && (n == DB - 1) && !(m_stop_end[c] >= 0 && m_stop_cmd[c] < t);
        bend = t + (acc + len - e);
      end
      acc += len;
    end
    bs = 1'b1;
  endtask

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_active[c] = 0; m_idle[c] = 1'b0; m_stop_end[c] = -1; m_stop_cmd[c] = -1;
      m_t0[c] = 0; m_out[c] = '0; m_freq[c] = '0; m_rep[c] = 0;
    end
    pk.delete();
    err_t = -1;
  endtask

  task automatic model_cmd(input logic [7:0] op, input logic [7:0] fp, input logic [7:0] cmd, input int t);
    int ch, bend;
    logic s, bt, dn, bs;
    ch = int'(cmd[6:3]);
    $display("[TB] cycle %0d cmd ch%0d start=%b stop=%b mode=%b idle=%b out=%h freq=%h",
             t, ch, cmd[0], cmd[1], cmd[2], cmd[7], op, fp);
    if (ch >= NCH) begin
      err_t = t + 1;
      return;
    end
    ch_eval(ch, t, s, bt, dn, bs, bend);
    if (cmd[0]) begin
      m_active[ch] = 1; m_t0[ch] = t + 1; m_out[ch] = op; m_freq[ch] = fp;
      m_rep[ch] = cmd[2]; m_idle[ch] = cmd[7]; m_stop_end[ch] = -1; m_stop_cmd[ch] = -1;
    end else if (cmd[1]) begin
      if (bs && m_stop_end[ch] < 0) begin
        m_stop_end[ch] = bend;
        m_stop_cmd[ch] = t;
      end
    end else if (!bs) begin
      m_active[ch] = 0;
      m_idle[ch]   = cmd[7];
    end
  endtask

  task automatic model_byte(input logic [7:0] b, input int t);
    if (pk.size() > 0 && t - last_t > TMO) pk.delete();
    pk.push_back(b);
    last_t = t;
    if (pk.size() == 3) begin
      model_cmd(pk[0], pk[1], b, t);
      pk.delete();
    end
  endtask

  task automatic check_all();
    int bend;
    logic s, bt, dn, bs;
    for (int c = 0; c < NCH; c++) begin
      ch_eval(c, cyc, s, bt, dn, bs, bend);
      chk("serial",   c, o_serial_out[c], s);
      chk("bit_tick", c, o_bit_tick[c],   bt);
      chk("done",     c, o_done_tick[c],  dn);
      chk("busy",     c, o_busy[c],       bs);
    end
    chk("cmd_err", 0, o_cmd_err, (cyc == err_t));
  endtask

  task automatic check_zero();
    for (int c = 0; c < NCH; c++) begin
      chk("rst_serial",   c, o_serial_out[c], 1'b0);
      chk("rst_bit_tick", c, o_bit_tick[c],   1'b0);
      chk("rst_done",     c, o_done_tick[c],  1'b0);
      chk("rst_busy",     c, o_busy[c],       1'b0);
    end
    chk("rst_cmd_err", 0, o_cmd_err, 1'b0);
  endtask

  task automatic run_cycle(input logic tk, input logic [7:0] d);
    @(posedge clk);
    #1;
    cyc++;
    i_rx_done_tick = tk;
    i_data = d;
    @(negedge clk);
    check_all();
    if (tk) model_byte(d, cyc);
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) run_cycle(1'b0, 8'($urandom));
  endtask

  task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2, input int gap);
    run_cycle(1'b1, b0);
    idle_cycles(gap);
    run_cycle(1'b1, b1);
    idle_cycles(gap);
    run_cycle(1'b1, b2);
  endtask

  task automatic mid_reset();
    @(posedge clk);
    #3;
    rst = 1'b1;
    i_rx_done_tick = 1'b0;
    #1;
    check_zero();
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  int gaps [6] = '{0, 1, 3, 49, 50, 55};

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_zero();
    @(negedge clk);
    rst = 1'b0;
    idle_cycles(3);

    // Single one-shot on ch0 at the fast rate.
    send_pkt(8'h55, 8'hFF, 8'h01, 2);
    idle_cycles(24);

    // Repeat on ch1 with mixed bit lengths, then a stop with idle-high retained.
    send_pkt(8'h0F, 8'h0F, 8'h8D, 1);
    idle_cycles(57);
    send_pkt(8'h00, 8'h00, 8'h0A, 1);
    idle_cycles(30);

    // A 60-clock gap throws away the two-byte prefix.
    run_cycle(1'b1, 8'h12);
    run_cycle(1'b1, 8'h34);
    idle_cycles(60);
    send_pkt(8'h55, 8'hFF, 8'h01, 0);
    idle_cycles(20);

    // Gap exactly at the timeout limit still completes the packet.
    run_cycle(1'b1, 8'hA5);
    idle_cycles(TMO - 1);
    run_cycle(1'b1, 8'h3C);
    idle_cycles(TMO - 1);
    run_cycle(1'b1, 8'h15);
    idle_cycles(10);

    // Out-of-range channel while ch2 repeats.
    send_pkt(8'hC3, 8'h5A, 8'h15, 0);
    idle_cycles(5);
    send_pkt(8'hFF, 8'hFF, 8'h29, 0);
    idle_cycles(30);

    // Randomized packets and gaps.
    for (int p = 0; p < 40; p++) begin
      logic [7:0] b0, b1, b2;
      int g;
      b0 = 8'($urandom);
      b1 = 8'($urandom);
      b2 = 8'($urandom);
      b2[6:3] = 4'($urandom_range(0, 5));
      g = gaps[$urandom_range(0, 5)];
      if (g > 3 && ($urandom_range(0, 3) != 0)) g = 1;
      send_pkt(b0, b1, b2, g);
      idle_cycles($urandom_range(0, 30));
    end

    // Reset in the middle of bits on ch0 and ch2.
    send_pkt(8'hAA, 8'h00, 8'h05, 0);
    send_pkt(8'h5A, 8'hF0, 8'h95, 0);
    idle_cycles(7);
    mid_reset();
    idle_cycles(40);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
